// File: rtl/latency_mem.sv
// Byte-addressable word memory with fixed, parameterised read and write latencies.
// One access is in flight at a time; completion is signalled by one-cycle ready pulses.
module latency_mem #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_mem_size,
  output logic [31:0] o_data,
  output logic        o_data_ready,
  output logic        o_write_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t         state_r;
  logic [3:0]     cnt_r;
  logic [AW+1:0]  addr_r;
  logic [1:0]     size_r;
  logic [31:0]    wdata_r;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  word_idx_s;
  logic [31:0]    rd_word_s;
  logic           wr_fire_s;
  logic           unused_addr_s;

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    lane_mask = 32'h0000_00FF << {lo, 3'b000};
      2'd1:    lane_mask = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      2'd2:    lane_mask = 32'hFFFF_FFFF;
      default: lane_mask = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd0:    lane_wdata = {4{data[7:0]}};
      2'd1:    lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      2'd0:    lane_rdata = {24'h00_0000, sh[7:0]};
      2'd1:    lane_rdata = {16'h0000, lo[1] ? word[31:16] : word[15:0]};
      2'd2:    lane_rdata = word;
      default: lane_rdata = 32'h0000_0000;
    endcase
  endfunction

  // Address bits above the storage range alias onto the same words.
  assign unused_addr_s = ^i_addr[31:AW+2];
  assign word_idx_s    = addr_r[AW+1:2];
  assign rd_word_s     = mem[word_idx_s];
  assign wr_fire_s     = (state_r == WR_WAIT) && (cnt_r == 4'd0);

  // Storage merge on the write completion edge; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (wr_fire_s) begin
      mem[word_idx_s] <= (rd_word_s & ~lane_mask(size_r, addr_r[1:0]))
                       | (lane_wdata(size_r, wdata_r) & lane_mask(size_r, addr_r[1:0]));
    end
  end

  // Access sequencing: latch request in IDLE, count down, pulse ready on completion.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      addr_r        <= {(AW+2){1'b0}};
      size_r        <= 2'd0;
      wdata_r       <= 32'h0000_0000;
      o_data        <= 32'h0000_0000;
      o_data_ready  <= 1'b0;
      o_write_ready <= 1'b0;
    end else begin
      o_data_ready  <= 1'b0;
      o_write_ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_re) begin
            addr_r  <= i_addr[AW+1:0];
            size_r  <= i_mem_size;
            cnt_r   <= RD_CNT;
            state_r <= RD_WAIT;
          end else if (i_we) begin
            addr_r  <= i_addr[AW+1:0];
            size_r  <= i_mem_size;
            wdata_r <= i_data;
            cnt_r   <= WR_CNT;
            state_r <= WR_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt_r == 4'd0) begin
            o_data       <= lane_rdata(size_r, addr_r[1:0], rd_word_s);
            o_data_ready <= 1'b1;
            state_r      <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt_r == 4'd0) begin
            o_write_ready <= 1'b1;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latency_mem.sv
// Bench for latency_mem: vector table plus scoreboard of expected completions,
// and a second instance with WRITE_LATENCY=3 for the reset-abort case.
module tb_latency_mem;

  localparam int RL  = 2;
  localparam int WL  = 1;
  localparam int RL3 = 2;
  localparam int WL3 = 3;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn, re, we;
  logic [31:0] addr, data;
  logic [1:0]  size;
  logic [31:0] o_data;
  logic        o_data_ready, o_write_ready;

  logic        rstn3, re3, we3;
  logic [31:0] addr3, data3;
  logic [1:0]  size3;
  logic [31:0] o_data3;
  logic        o_data_ready3, o_write_ready3;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;
  int          wr3_pulses = 0;
  logic [31:0] last_rd = 32'h0;
  exp_t        sb[$];
  exp_t        e_mon;
  vec_t        vecs[20];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  latency_mem dut (
    .i_clk(clk), .i_rstn(rstn), .i_re(re), .i_we(we), .i_addr(addr), .i_data(data),
    .i_mem_size(size), .o_data(o_data), .o_data_ready(o_data_ready),
    .o_write_ready(o_write_ready)
  );

  latency_mem #(.DEPTH_WORDS(1024), .READ_LATENCY(RL3), .WRITE_LATENCY(WL3)) dut3 (
    .i_clk(clk), .i_rstn(rstn3), .i_re(re3), .i_we(we3), .i_addr(addr3), .i_data(data3),
    .i_mem_size(size3), .o_data(o_data3), .o_data_ready(o_data_ready3),
    .o_write_ready(o_write_ready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_data_ready && o_write_ready) chk("ready_overlap", 32'h1, 32'h0);
      if (o_data_ready) begin
        rd_pulses++;
        if (sb.size() == 0 || !sb[0].is_rd) begin
          chk("unexpected_rd_pulse", 32'h1, 32'h0);
        end else begin
          e_mon = sb.pop_front();
          chk("rd_data", o_data, e_mon.data);
          chk("rd_cycle", 32'(cyc), 32'(e_mon.due));
          last_rd = e_mon.data;
        end
      end
      if (o_write_ready) begin
        if (sb.size() == 0 || sb[0].is_rd) begin
          chk("unexpected_wr_pulse", 32'h1, 32'h0);
        end else begin
          e_mon = sb.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e_mon.due));
          chk("wr_keeps_odata", o_data, last_rd);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_write_ready3) wr3_pulses++;
  end

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    re   = v.re;
    we   = v.we;
    addr = v.addr;
    data = v.data;
    size = v.size;
    if (v.re) begin
      e.is_rd = 1'b1; e.data = v.exp; e.due = cyc + 1 + RL;
      sb.push_back(e);
    end else if (v.we) begin
      e.is_rd = 1'b0; e.data = 32'h0; e.due = cyc + 1 + WL;
      sb.push_back(e);
    end
    @(negedge clk);
    re   = 1'b0;
    we   = 1'b0;
    addr = $urandom();
    data = $urandom();
    size = 2'($urandom_range(0, 3));
    drain("vec");
  endtask

  task automatic wait3(input bit rd, input int due, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (rd ? o_data_ready3 : o_write_ready3) begin
        found = 1'b1;
        chk({name, "_cycle"}, 32'(cyc), 32'(due));
      end
    end
    if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int c, p0;
    //            re    we    addr          data          size  expected read
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 2'd2, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'd2, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 2'd2, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFA5, 2'd0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,        2'd1, 32'h0000_A500};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'd2, 32'hA500_0000};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        2'd0, 32'h0000_00A5};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        2'd1, 32'h0000_A500};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0011, 32'hFFFF_1234, 2'd1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,        2'd2, 32'hA500_1234};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0011, 32'h0,        2'd0, 32'h0000_0012};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 2'd2, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        2'd2, 32'h1234_5678};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 2'd3, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        2'd2, 32'h1234_5678};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        2'd3, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_1010, 32'h0,        2'd2, 32'hA500_1234};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2'd2, 32'h0};
    vecs[18] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, 2'd2, 32'hCAFE_F00D};
    vecs[19] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        2'd2, 32'hCAFE_F00D};

    rstn = 1'b0; re = 1'b0; we = 1'b0; addr = 32'h0; data = 32'h0; size = 2'd0;
    rstn3 = 1'b0; re3 = 1'b0; we3 = 1'b0; addr3 = 32'h0; data3 = 32'h0; size3 = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_odata", o_data, 32'h0);
    chk("rst_rd_ready", {31'h0, o_data_ready}, 32'h0);
    chk("rst_wr_ready", {31'h0, o_write_ready}, 32'h0);
    chk("rst3_odata", o_data3, 32'h0);
    rstn  = 1'b1;
    rstn3 = 1'b1;

    // First vector is driven in the same half-cycle reset is released.
    for (int i = 0; i < 20; i++) apply(vecs[i]);

    // Read held high: three back-to-back reads, address changed while waiting.
    c  = cyc;
    p0 = rd_pulses;
    re = 1'b1; we = 1'b0; addr = 32'h0000_0010; size = 2'd2;
    sb.push_back('{1'b1, 32'hA500_1234, c + 1 + RL});
    sb.push_back('{1'b1, 32'h1234_5678, c + 4 + RL});
    sb.push_back('{1'b1, 32'hCAFE_F00D, c + 7 + RL});
    @(negedge clk);
    addr = 32'h0000_0000;
    repeat (3) @(negedge clk);
    addr = 32'h0000_0020;
    repeat (3) @(negedge clk);
    re = 1'b0;
    drain("held_re");
    repeat (4) @(negedge clk);
    chk("held_re_pulses", 32'(rd_pulses - p0), 32'd3);

    // Second instance: write, read back, then abort a write with reset.
    @(negedge clk);
    we3 = 1'b1; addr3 = 32'h40; data3 = 32'h0BAD_F00D; size3 = 2'd2;
    c = cyc;
    @(negedge clk);
    we3 = 1'b0;
    wait3(1'b0, c + 1 + WL3, "wr3");

    re3 = 1'b1; addr3 = 32'h40; size3 = 2'd2;
    c = cyc;
    @(negedge clk);
    re3 = 1'b0;
    wait3(1'b1, c + 1 + RL3, "rd3");
    chk("rd3_data", o_data3, 32'h0BAD_F00D);

    p0 = wr3_pulses;
    we3 = 1'b1; addr3 = 32'h40; data3 = 32'hFFFF_FFFF; size3 = 2'd2;
    @(negedge clk);
    we3 = 1'b0;
    rstn3 = 1'b0;
    #1;
    chk("abort_odata", o_data3, 32'h0);
    @(negedge clk);
    rstn3 = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_wr_pulse", 32'(wr3_pulses - p0), 32'd0);

    re3 = 1'b1; addr3 = 32'h40; size3 = 2'd2;
    c = cyc;
    @(negedge clk);
    re3 = 1'b0;
    wait3(1'b1, c + 1 + RL3, "rd3_after_abort");
    chk("abort_word_unchanged", o_data3, 32'h0BAD_F00D);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latency_mem.md
LATENCY_MEM -- requirements
Module: latency_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in storage (power of two, 4..65536).
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning the number of cycles from read acceptance to o_data_ready (1..15).
REQ-003 SHALL have parameter WRITE_LATENCY, default 1, meaning the number of cycles from write acceptance to o_write_ready (1..15).
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 i_re  input  1  read request.
REQ-007 i_we  input  1  write request.
REQ-008 i_addr  input  32  byte address.
REQ-009 i_data  input  32  write data, right-justified.
REQ-010 i_mem_size  input  2  access size: 0=BYTE, 1=HWORD, 2=WORD, 3=invalid.
REQ-011 o_data  output  32  read data, right-justified and zero-extended.
REQ-012 o_data_ready  output  1  one-cycle pulse marking read completion.
REQ-013 o_write_ready  output  1  one-cycle pulse marking write completion.

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT and WR_WAIT; state SHALL be IDLE after reset.
REQ-015 In IDLE, i_re=1 SHALL accept a read: latch address and size, load the counter with READ_LATENCY-1, go to RD_WAIT.
REQ-016 In IDLE, i_we=1 with i_re=0 SHALL accept a write: latch address, size and data, load the counter with WRITE_LATENCY-1, go to WR_WAIT.
REQ-017 If i_re and i_we are both 1 in IDLE, the read SHALL win and the write SHALL be dropped without side effect.
REQ-018 In RD_WAIT/WR_WAIT, i_re, i_we, i_addr, i_data and i_mem_size SHALL be ignored; only latched values are used.
REQ-019 The counter SHALL decrement once per cycle in a WAIT state; at 0 the access completes and the FSM returns to IDLE on the same edge.
REQ-020 A request accepted at edge T SHALL produce its ready pulse high during cycle T+LAT, where LAT is the matching latency parameter.
REQ-021 A request still asserted in the IDLE cycle after completion SHALL be accepted as a new request (back-to-back allowed).
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 Alignment: BYTE uses lane addr[1:0]; HWORD uses addr[1] and ignores addr[0]; WORD ignores addr[1:0]; no misalignment fault is raised.
REQ-024 Write: BYTE writes i_data[7:0] to the selected byte lane; HWORD writes i_data[15:0] to the selected halfword; WORD writes all 32 bits; other lanes SHALL be unchanged.
REQ-025 The storage update SHALL occur on the completion edge of a write, not on acceptance.
REQ-026 Read: the word SHALL be sampled on the completion edge; o_data SHALL be updated on that edge and valid during the o_data_ready cycle.
REQ-027 Read lane selection SHALL shift the selected lane to the LSBs and zero-fill the upper bits; sign extension is the requester's job.
REQ-028 o_data SHALL hold its last value until the next read completes; writes SHALL NOT modify o_data.
REQ-029 i_mem_size=3 SHALL complete with normal latency and ready pulse; a read SHALL return 32'h0 and a write SHALL leave storage unchanged.
REQ-030 o_data_ready and o_write_ready SHALL NOT be asserted simultaneously and SHALL each be high for exactly one cycle per completed access.

Reset
REQ-031 i_rstn=0 SHALL immediately force state=IDLE, counter=0, o_data=32'h0, o_data_ready=0, o_write_ready=0.
REQ-032 Storage contents SHALL NOT be reset, and storage is undefined at power-up.
REQ-033 Reset during RD_WAIT/WR_WAIT SHALL abort the access: no ready pulse; an aborted write SHALL NOT modify storage.
REQ-034 The first request SHALL be accepted on the first rising edge with i_rstn=1.

Verification
REQ-035 Defaults: WORD write of 32'hDEADBEEF to 0x10, then WORD read of 0x10 -> o_write_ready pulses 1 cycle after acceptance; o_data_ready pulses 2 cycles after acceptance with o_data=32'hDEADBEEF.
REQ-036 BYTE write of 8'hA5 to 0x13 over word 32'h00000000, then HWORD read of 0x12 -> o_data=32'h0000A500; WORD read of 0x10 -> 32'hA5000000.
REQ-037 i_re and i_we both high in IDLE with WORD size at address 0x20 -> read completes, no o_write_ready pulse, and address 0x20 is unchanged.
REQ-038 DEPTH_WORDS=1024: WORD write of 32'h12345678 to 0x1000, then read of 0x0 -> o_data=32'h12345678 (wrap).
REQ-039 i_rstn pulsed low one cycle after a WORD write is accepted with WRITE_LATENCY=3 -> no o_write_ready pulse, target word unchanged, o_data=0.
REQ-040 i_re held high continuously for 3 reads with READ_LATENCY=2 -> exactly 3 o_data_ready pulses, each 3 cycles apart (IDLE acceptance cycle plus latency); o_data matches the latched address of each read.
